// File: rtl/ula_pkg.sv
// ula_pkg: shared widths, FSM state encoding and ALU operation codes
package ula_pkg;

    localparam int OPERAND_W = 4;
    localparam int OP_W      = 3;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_EXEC = 2'd3
    } seq_state_t;

    localparam logic [OP_W-1:0] OP_SOMA = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_MULT = 3'b101;
    localparam logic [OP_W-1:0] OP_DIV  = 3'b110;

    // Previous field for the back key; the first field has nowhere to go
    function automatic seq_state_t seq_back(input seq_state_t s);
        return (s == S_A) ? S_A : seq_state_t'(s - 2'd1);
    endfunction

endpackage

// File: rtl/ula_key_debounce.sv
// ula_key_debounce: 2-FF synchronizer, optional debounce (ULA_KEY_DEBOUNCE_EN), 1-clk press pulse
module ula_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse
);

    logic sync1, sync2, deb, deb_next;

`ifdef ULA_KEY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt, cnt_inc, cnt_next;

    assign cnt_inc = cnt + 1'b1;

    // Accept the synced level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        deb_next = deb;
        cnt_next = '0;
        if (sync2 != deb) begin
            if (cnt_inc == CW'(DEBOUNCE_CYCLES))
                deb_next = sync2;
            else
                cnt_next = cnt_inc;
        end
    end

    // Stability counter
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt_next;
    end
`else
    localparam int unused_cycles = DEBOUNCE_CYCLES;

    assign deb_next = sync2;
`endif

    // Synchronize, track debounced level and pulse on its falling edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            deb         <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= key_n;
            sync2       <= sync1;
            deb         <= deb_next;
            press_pulse <= deb & ~deb_next;
        end
    end

endmodule

// File: rtl/ula_operand_sequencer.sv
// ula_operand_sequencer: key-driven capture of A, B, OP/Cin for the ALU (debounce via ULA_KEY_DEBOUNCE_EN)
module ula_operand_sequencer
    import ula_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPERAND_W-1:0] sw_data,
    input  logic                 sw_cin,
    input  logic                 key_enter_n,
    input  logic                 key_back_n,
    output logic [OPERAND_W-1:0] a_out,
    output logic [OPERAND_W-1:0] b_out,
    output logic [OP_W-1:0]      op_out,
    output logic                 cin_out,
    output logic                 operands_valid,
    output logic [1:0]           state_out
);

    logic       enter_p, back_p;
    seq_state_t state;

    ula_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clk), .rst_n(rst_n), .key_n(key_enter_n), .press_pulse(enter_p)
    );

    ula_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
        .clk(clk), .rst_n(rst_n), .key_n(key_back_n), .press_pulse(back_p)
    );

    // Field walk: enter captures the current field and advances, back only steps the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_A;
            a_out          <= '0;
            b_out          <= '0;
            op_out         <= '0;
            cin_out        <= 1'b0;
            operands_valid <= 1'b0;
        end else if (enter_p && !back_p) begin
            case (state)
                S_A:     a_out <= sw_data;
                S_B:     b_out <= sw_data;
                S_OP: begin
                    op_out  <= sw_data[OP_W-1:0];
                    cin_out <= sw_cin;
                end
                default: ;
            endcase
            state          <= seq_state_t'(state + 2'd1);
            operands_valid <= (state == S_OP);
        end else if (back_p && !enter_p) begin
            state          <= seq_back(state);
            operands_valid <= 1'b0;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_ula_operand_sequencer.sv
// tb_ula_operand_sequencer: directed scenarios plus random key/switch traffic against a sample-window model
module tb_ula_operand_sequencer;

    localparam int D = 4;
`ifdef ULA_KEY_DEBOUNCE_EN
    localparam int LAT = D + 3;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw_data = 4'h0;
    logic       sw_cin = 1'b0;
    logic       key_enter_n = 1'b1;
    logic       key_back_n = 1'b1;
    logic [3:0] a_out, b_out;
    logic [2:0] op_out;
    logic       cin_out, operands_valid;
    logic [1:0] state_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ula_operand_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .sw_cin(sw_cin),
        .key_enter_n(key_enter_n), .key_back_n(key_back_n),
        .a_out(a_out), .b_out(b_out), .op_out(op_out), .cin_out(cin_out),
        .operands_valid(operands_valid), .state_out(state_out)
    );

    // Reference model: key sample history per edge; a level is accepted once the
    // last D synchronized samples all disagree with it; FSM is plain modular stepping
    logic [15:0] he = '1, hb = '1;
    logic        de = 1'b1, db = 1'b1, pe = 1'b0, pb = 1'b0;
    logic [1:0]  ms = 2'd0;
    logic [3:0]  ma = 4'h0, mb = 4'h0;
    logic [2:0]  mo = 3'h0;
    logic        mc = 1'b0;

    function automatic logic all_eq(input logic [15:0] h, input logic v);
        for (int i = 1; i <= D; i++) if (h[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        he <= {he[14:0], rst_n ? key_enter_n : 1'b1};
        hb <= {hb[14:0], rst_n ? key_back_n : 1'b1};
        if (!rst_n) begin
            ms <= 2'd0; ma <= 4'h0; mb <= 4'h0; mo <= 3'h0; mc <= 1'b0;
            pe <= 1'b0; pb <= 1'b0; de <= 1'b1; db <= 1'b1;
        end else begin
            if (pe && !pb) begin
                if (ms == 2'd0) ma <= sw_data;
                if (ms == 2'd1) mb <= sw_data;
                if (ms == 2'd2) begin mo <= sw_data[2:0]; mc <= sw_cin; end
                ms <= (ms + 2'd1) % 4;
            end else if (pb && !pe) begin
                ms <= (ms == 2'd0) ? 2'd0 : ms - 2'd1;
            end
`ifdef ULA_KEY_DEBOUNCE_EN
            pe <= de && all_eq(he, 1'b0);
            pb <= db && all_eq(hb, 1'b0);
            de <= de ? !all_eq(he, 1'b0) : all_eq(he, 1'b1);
            db <= db ? !all_eq(hb, 1'b0) : all_eq(hb, 1'b1);
`else
            pe <= !he[1] && he[2];
            pb <= !hb[1] && hb[2];
`endif
        end
    end

    wire [14:0] obs = {a_out, b_out, op_out, cin_out, operands_valid, state_out};
    wire [14:0] mdl = {ma, mb, mo, mc, ms == 2'd3, ms};

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic e, input logic b, input logic [3:0] sw, input logic c);
        @(negedge clk);
        sw_data = sw; sw_cin = c; key_enter_n = !e; key_back_n = !b;
        hold(LAT + 1);
        key_enter_n = 1'b1; key_back_n = 1'b1;
        hold(LAT + 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_enter_n = 1'b1; key_back_n = 1'b1; sw_data = 4'hA; sw_cin = 1'b1;
        hold(3);
        rst_n = 1'b1;
        hold(1);
        total++;
        if (obs !== 15'h0) begin bad++; $display("FAIL reset_outputs: got %h want %h", obs, 15'h0); end
        total++;
        if (obs !== mdl) begin bad++; $display("FAIL reset_model: got %h want %h", obs, mdl); end
    endtask

    task automatic test_enter_seq();
        press(1'b1, 1'b0, 4'h9, 1'b0);
        total++;
        if ({a_out, state_out} !== {4'h9, 2'd1}) begin bad++; $display("FAIL enter_a: got %h want %h", {a_out, state_out}, {4'h9, 2'd1}); end
        press(1'b1, 1'b0, 4'h3, 1'b0);
        total++;
        if ({b_out, state_out, operands_valid} !== {4'h3, 2'd2, 1'b0}) begin bad++; $display("FAIL enter_b: got %h want %h", {b_out, state_out, operands_valid}, {4'h3, 2'd2, 1'b0}); end
        press(1'b1, 1'b0, 4'b0101, 1'b1);
        total++;
        if (obs !== {4'h9, 4'h3, 3'b101, 1'b1, 1'b1, 2'd3}) begin bad++; $display("FAIL enter_op: got %h want %h", obs, {4'h9, 4'h3, 3'b101, 1'b1, 1'b1, 2'd3}); end
        total++;
        if (obs !== mdl) begin bad++; $display("FAIL enter_model: got %h want %h", obs, mdl); end
    endtask

    task automatic test_glitch();
        int elapsed;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (obs !== mdl) begin bad++; $display("FAIL glitch_model[%0d]: got %h want %h", i, obs, mdl); end
            key_enter_n = ((i / 2) % 2) == 1;
        end
`ifdef ULA_KEY_DEBOUNCE_EN
        elapsed = 1;
        while (state_out == 2'd3 && elapsed < 40) begin
            @(negedge clk);
            elapsed++;
        end
        total++;
        if (elapsed != LAT || state_out !== 2'd0) begin bad++; $display("FAIL glitch_latency: got %0d/%0d want %0d/0", elapsed, state_out, LAT); end
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (obs !== mdl) begin bad++; $display("FAIL glitch_hold[%0d]: got %h want %h", i, obs, mdl); end
`ifdef ULA_KEY_DEBOUNCE_EN
            total++;
            if (state_out !== 2'd0) begin bad++; $display("FAIL glitch_single[%0d]: got %0d want 0", i, state_out); end
`endif
        end
        key_enter_n = 1'b1;
        hold(LAT + 1);
        total++;
        if (obs !== mdl) begin bad++; $display("FAIL glitch_release: got %h want %h", obs, mdl); end
    endtask

    task automatic test_back();
        logic [7:0] sab;
        logic [3:0] soc;
        for (int i = 0; i < 4 && ms != 2'd3; i++)
            press(1'b1, 1'b0, 4'($urandom), 1'($urandom));
        sab = {ma, mb};
        soc = {mo, mc};
        press(1'b0, 1'b1, 4'($urandom), 1'($urandom));
        total++;
        if ({state_out, operands_valid, a_out, b_out, op_out, cin_out} !== {2'd2, 1'b0, sab, soc}) begin
            bad++; $display("FAIL back_exec: got %h want %h", {state_out, operands_valid, a_out, b_out, op_out, cin_out}, {2'd2, 1'b0, sab, soc});
        end
        press(1'b0, 1'b1, 4'h0, 1'b0);
        press(1'b0, 1'b1, 4'h0, 1'b0);
        total++;
        if ({state_out, a_out, b_out} !== {2'd0, sab}) begin bad++; $display("FAIL back_to_a: got %h want %h", {state_out, a_out, b_out}, {2'd0, sab}); end
        press(1'b0, 1'b1, 4'h0, 1'b0);
        total++;
        if (state_out !== 2'd0) begin bad++; $display("FAIL back_sat: got %0d want 0", state_out); end
        total++;
        if (obs !== mdl) begin bad++; $display("FAIL back_model: got %h want %h", obs, mdl); end
    endtask

    task automatic test_both();
        logic [3:0] sb, sa;
        press(1'b1, 1'b0, 4'h6, 1'b0);
        sb = mb;
        sa = ma;
        press(1'b1, 1'b1, 4'hC, 1'b1);
        total++;
        if ({state_out, a_out, b_out} !== {2'd1, 4'h6, sb}) begin bad++; $display("FAIL both_keys: got %h want %h", {state_out, a_out, b_out}, {2'd1, 4'h6, sb}); end
        total++;
        if (a_out !== sa) begin bad++; $display("FAIL both_keys_a: got %h want %h", a_out, sa); end
    endtask

    task automatic test_reset_mid();
        press(1'b0, 1'b1, 4'h0, 1'b0);
        press(1'b1, 1'b0, 4'hF, 1'b0);
        press(1'b1, 1'b0, 4'h1, 1'b0);
        total++;
        if ({state_out, a_out, b_out} !== {2'd2, 4'hF, 4'h1}) begin bad++; $display("FAIL mid_setup: got %h want %h", {state_out, a_out, b_out}, {2'd2, 4'hF, 4'h1}); end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({state_out, a_out, b_out, operands_valid} !== 11'h0) begin bad++; $display("FAIL mid_reset: got %h want %h", {state_out, a_out, b_out, operands_valid}, 11'h0); end
        rst_n = 1'b1;
        hold(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            total++;
            if (obs !== mdl) begin bad++; $display("FAIL random[%0d]: got %h want %h", i, obs, mdl); end
            sw_data = 4'($urandom);
            sw_cin = 1'($urandom);
            if ($urandom_range(0, 7) == 0) key_enter_n = ~key_enter_n;
            if ($urandom_range(0, 9) == 0) key_back_n = ~key_back_n;
            rst_n = ($urandom_range(0, 249) != 0);
        end
        rst_n = 1'b1; key_enter_n = 1'b1; key_back_n = 1'b1;
        hold(LAT + 2);
        total++;
        if (obs !== mdl) begin bad++; $display("FAIL random_end: got %h want %h", obs, mdl); end
    endtask

    initial begin
        test_reset();
        test_enter_seq();
        test_glitch();
        test_back();
        test_both();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
